seq_restoring_divider: RTL and testbench

SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

---
 rtl/seq_restoring_divider.sv | 97 +++++++++
 tb/tb_seq_restoring_divider.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero skips the iteration and returns all-ones / dividend.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;    // dividend bits shift out the top, quotient bits shift in below
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] prem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             keep;
  logic             last;
  logic             accept;

  assign accept  = start && (state != CALC);
  assign shifted = {prem, dvd[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr};
  // shifted < 2*dsr always holds, so the top bit of trial is exactly the borrow
  assign keep    = ~trial[WIDTH];
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      prem        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      dvd  <= dividend;
      dsr  <= divisor;
      prem <= '0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      prem <= keep ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      dvd  <= {dvd[WIDTH-2:0], keep};
      cnt  <= cnt + CW'(1);
      if (last) begin
        quotient    <= {dvd[WIDTH-2:0], keep};
        remainder   <= keep ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks of the sequential divider against plain / and % arithmetic.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_q(input int a, input int b);
    return (b == 0) ? W'((1 << W) - 1) : W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_r(input int a, input int b);
    return (b == 0) ? W'(a) : W'(a % b);
  endfunction

  task automatic check_result(input string tag, input int a, input int b);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_in_done"}, 32'(busy), 32'd0);
    check({tag, ".q"}, 32'(quotient), 32'(ref_q(a, b)));
    check({tag, ".r"}, 32'(remainder), 32'(ref_r(a, b)));
    check({tag, ".dbz"}, 32'(div_by_zero), (b == 0) ? 32'd1 : 32'd0);
  endtask

  // one complete division with timing checks; operand inputs are scrambled after accept
  task automatic run_div(input string tag, input int a, input int b);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    if (b != 0) begin
      for (int i = 0; i < W; i++) begin
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".no_early_done"}, 32'(done), 32'd0);
        tick();
      end
    end
    check_result(tag, a, b);
    tick();
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".q_hold"}, 32'(quotient), 32'(ref_q(a, b)));
    check({tag, ".r_hold"}, 32'(remainder), 32'(ref_r(a, b)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick();
    tick();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.q", 32'(quotient), 32'd0);
    check("rst.r", 32'(remainder), 32'd0);
    check("rst.dbz", 32'(div_by_zero), 32'd0);
    // start during reset must lose to reset
    start = 1'b1; dividend = 4'd9; divisor = 4'd3;
    tick();
    check("rst_prio.busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    tick();

    run_div("d9_3", 9, 3);
    run_div("d15_4", 15, 4);
    run_div("d15_1", 15, 1);
    run_div("d7_0", 7, 0);
    run_div("d9_3_after_dbz", 9, 3);

    // start held through DONE: back-to-back with no idle cycle
    dividend = 4'd0; divisor = 4'd5; start = 1'b1;
    tick();
    dividend = 4'd14; divisor = 4'd5;
    for (int i = 0; i < W; i++) begin
      check("b2b.busy1", 32'(busy), 32'd1);
      tick();
    end
    check_result("b2b.first", 0, 5);
    tick();
    start = 1'b0;
    check("b2b.no_idle", 32'(busy), 32'd1);
    check("b2b.done_drop", 32'(done), 32'd0);
    for (int i = 1; i < W; i++) tick();
    check("b2b.busy_last", 32'(busy), 32'd1);
    tick();
    check_result("b2b.second", 14, 5);
    tick();

    // start during CALC is ignored
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dividend = 4'd8; divisor = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 2; i < W; i++) tick();
    check_result("ign13_3", 13, 3);
    tick();

    // reset in CALC cycle 3 aborts with no done
    dividend = 4'd11; divisor = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.q", 32'(quotient), 32'd0);
    check("abort.r", 32'(remainder), 32'd0);
    check("abort.dbz", 32'(div_by_zero), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("abort.no_done", 32'(done), 32'd0);
    end
    run_div("d6_4", 6, 4);

    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++)
        run_div($sformatf("sweep_%0d_%0d", a, b), a, b);

    for (int i = 0; i < 40; i++)
      run_div("rand", int'($urandom_range(15)), int'($urandom_range(15)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
